// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back L1 data cache.
// Hits are answered combinationally in the request cycle. Misses stall the
// requester by holding mem_resp low. A dirty victim is written back to the
// 128-bit physical port first, and then the line is filled from that port.
// Optional build macro: L1_DCACHE_PERF_CNT_EN adds the saturating
// hit_count / miss_count outputs.
module l1_dcache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [127:0] pmem_rdata,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp
`ifdef L1_DCACHE_PERF_CNT_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IDX   = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - 4 - IDX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  // Word extraction: word i of a line lives in bits [16i+15:16i].
  function automatic logic [15:0] get_word(input logic [127:0] line, input logic [2:0] off);
    return line[{off, 4'b0000} +: 16];
  endfunction

  // Replace one word of a line.
  function automatic logic [127:0] put_word(input logic [127:0] line, input logic [2:0] off,
                                            input logic [15:0] w);
    logic [127:0] r;
    r = line;
    r[{off, 4'b0000} +: 16] = w;
    return r;
  endfunction

  // Byte-masked merge of new write data into the old word.
  function automatic logic [15:0] merge_bytes(input logic [15:0] old_w, input logic [15:0] new_w,
                                              input logic [1:0] be);
    return {(be[1] ? new_w[15:8] : old_w[15:8]), (be[0] ? new_w[7:0] : old_w[7:0])};
  endfunction

  state_t             state_r;
  state_t             state_s;

  logic [127:0]       data_r [NUM_SETS];
  logic [TAG_W-1:0]   tag_r  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_r;
  logic [NUM_SETS-1:0] dirty_r;

  logic [2:0]         offset_s;
  logic [IDX-1:0]     index_s;
  logic [TAG_W-1:0]   tag_s;
  logic               req_s;
  logic               hit_s;
  logic [127:0]       cur_line_s;
  logic [127:0]       upd_line_s;
  logic               unused_s;

  logic               mem_resp_s;
  logic [15:0]        mem_rdata_s;
  logic               pmem_read_s;
  logic               pmem_write_s;
  logic [15:0]        pmem_address_s;
  logic [127:0]       pmem_wdata_s;
  logic               write_hit_s;
  logic               fill_s;
  logic               hit_evt_s;
  logic               miss_evt_s;

  assign offset_s   = mem_address[3:1];
  assign index_s    = mem_address[3+IDX:4];
  assign tag_s      = mem_address[15:4+IDX];
  assign unused_s   = mem_address[0];
  assign req_s      = mem_read | mem_write;
  assign cur_line_s = data_r[index_s];
  assign hit_s      = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign upd_line_s = put_word(cur_line_s, offset_s,
                               merge_bytes(get_word(cur_line_s, offset_s), mem_wdata, mem_byte_enable));

  // Next-state and output decode; a simultaneous read+write is handled as a write.
  always_comb begin
    state_s        = state_r;
    mem_resp_s     = 1'b0;
    mem_rdata_s    = 16'h0000;
    pmem_read_s    = 1'b0;
    pmem_write_s   = 1'b0;
    pmem_address_s = 16'h0000;
    pmem_wdata_s   = 128'h0;
    write_hit_s    = 1'b0;
    fill_s         = 1'b0;
    hit_evt_s      = 1'b0;
    miss_evt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            mem_resp_s = 1'b1;
            hit_evt_s  = 1'b1;
            if (mem_write) begin
              write_hit_s = 1'b1;
            end else begin
              mem_rdata_s = get_word(cur_line_s, offset_s);
            end
          end else begin
            miss_evt_s = 1'b1;
            if (valid_r[index_s] && dirty_r[index_s]) begin
              state_s = WRITEBACK;
            end else begin
              state_s = ALLOCATE;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITEBACK: begin
        pmem_write_s   = 1'b1;
        pmem_address_s = {tag_r[index_s], index_s, 4'b0000};
        pmem_wdata_s   = cur_line_s;
        if (pmem_resp) begin
          state_s = ALLOCATE;
        end else begin
          state_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        pmem_read_s    = 1'b1;
        pmem_address_s = {tag_s, index_s, 4'b0000};
        if (pmem_resp) begin
          fill_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = ALLOCATE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held so handshakes drop without waiting for a clock.
  assign mem_resp     = reset & mem_resp_s;
  assign mem_rdata    = reset ? mem_rdata_s : 16'h0000;
  assign pmem_read    = reset & pmem_read_s;
  assign pmem_write   = reset & pmem_write_s;
  assign pmem_address = reset ? pmem_address_s : 16'h0000;
  assign pmem_wdata   = reset ? pmem_wdata_s : 128'h0;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Line status bits: fill makes a line valid and clean, a write hit makes it dirty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (write_hit_s) begin
      dirty_r[index_s] <= 1'b1;
    end
  end

  // Line data and tag storage; contents need no reset since valid guards them.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[index_s] <= pmem_rdata;
      tag_r[index_s]  <= tag_s;
    end else if (write_hit_s) begin
      data_r[index_s] <= upd_line_s;
    end
  end

`ifdef L1_DCACHE_PERF_CNT_EN
  logic post_fill_r;

  // Marks the IDLE cycle right after a fill so its hit is not counted as a hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      post_fill_r <= 1'b0;
    end else if (fill_s) begin
      post_fill_r <= 1'b1;
    end else if (state_r == IDLE) begin
      post_fill_r <= 1'b0;
    end
  end

  // Saturating hit/miss counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if (hit_evt_s && !post_fill_r && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'h0001;
      end
      if (miss_evt_s && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
    end
  end
`else
  logic unused_evt_s;
  assign unused_evt_s = hit_evt_s | miss_evt_s;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: cold miss, hits, byte write, dirty and clean
// eviction, masked write, reset during fill, and optional counters.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_rdata;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
`ifdef L1_DCACHE_PERF_CNT_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  l1_dcache #(.NUM_SETS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_rdata      (pmem_rdata),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp)
`ifdef L1_DCACHE_PERF_CNT_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [1:0] be, input logic [15:0] wd);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
  endtask

  // Holds off pmem_resp for cycles-1 cycles, then acknowledges for one cycle.
  task automatic ack_pmem(input int cycles, input logic [127:0] line);
    repeat (cycles - 1) next_cycle();
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    next_cycle();
    pmem_resp  = 1'b0;
    pmem_rdata = 128'h0;
  endtask

  logic [127:0] line_a, line_b, line_c, line_d;

  initial begin
    line_a = 128'h0; line_a[15:0] = 16'h1234; line_a[31:16] = 16'h5634;
    line_b = 128'h0; line_b[15:0] = 16'h9000; line_b[31:16] = 16'h9002;
    line_c = 128'h0; line_c[15:0] = 16'h1100;
    line_d = 128'h0; line_d[15:0] = 16'h2020;

    reset = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata = 128'h0;
    drive_req(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_mem_resp", mem_resp, 1'b0);
    check_value("rst_pmem_read", pmem_read, 1'b0);
    check_value("rst_pmem_write", pmem_write, 1'b0);
    check_value("rst_pmem_addr", pmem_address, 16'h0000);
    check_value("rst_rdata", mem_rdata, 16'h0000);
    next_cycle();
    reset = 1'b1;

    // Test 1: cold read miss at 0x0010, fill acknowledged on the third cycle.
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);
    @(negedge clk);
    check_value("t1_miss_resp", mem_resp, 1'b0);
    next_cycle();
    @(negedge clk);
    check_value("t1_pmem_read", pmem_read, 1'b1);
    check_value("t1_pmem_addr", pmem_address, 16'h0010);
    check_value("t1_no_pmem_write", pmem_write, 1'b0);
    ack_pmem(3, line_a);
    @(negedge clk);
    check_value("t1_resp", mem_resp, 1'b1);
    check_value("t1_rdata", mem_rdata, 16'h1234);
    check_value("t1_pmem_read_off", pmem_read, 1'b0);

    // Test 2: read hit, byte write to the upper byte, read back.
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000);
    @(negedge clk);
    check_value("t2_hit_resp", mem_resp, 1'b1);
    check_value("t2_hit_rdata", mem_rdata, 16'h5634);
    check_value("t2_no_pmem", {pmem_read, pmem_write}, 2'b00);
    next_cycle();
    drive_req(1'b0, 1'b1, 16'h0012, 2'b10, 16'hABCD);
    @(negedge clk);
    check_value("t2_wr_resp", mem_resp, 1'b1);
    check_value("t2_wr_rdata", mem_rdata, 16'h0000);
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000);
    @(negedge clk);
    check_value("t2_rd2_resp", mem_resp, 1'b1);
    check_value("t2_rd2_rdata", mem_rdata, 16'hAB34);

    // Test 3: dirty eviction of line 1 by 0x0090.
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0090, 2'b00, 16'h0000);
    @(negedge clk);
    check_value("t3_miss_resp", mem_resp, 1'b0);
    next_cycle();
    @(negedge clk);
    check_value("t3_wb_write", pmem_write, 1'b1);
    check_value("t3_wb_no_read", pmem_read, 1'b0);
    check_value("t3_wb_addr", pmem_address, 16'h0010);
    check_value("t3_wb_word1", pmem_wdata[31:16], 16'hAB34);
    check_value("t3_wb_word0", pmem_wdata[15:0], 16'h1234);
    next_cycle();
    @(negedge clk);
    check_value("t3_wb_hold", pmem_write, 1'b1);
    ack_pmem(1, 128'h0);
    @(negedge clk);
    check_value("t3_alloc_read", pmem_read, 1'b1);
    check_value("t3_alloc_no_write", pmem_write, 1'b0);
    check_value("t3_alloc_addr", pmem_address, 16'h0090);
    check_value("t3_alloc_resp", mem_resp, 1'b0);
    ack_pmem(2, line_b);
    @(negedge clk);
    check_value("t3_resp", mem_resp, 1'b1);
    check_value("t3_rdata", mem_rdata, 16'h9000);

    // Test 4: clean eviction of line 1 by 0x0110.
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0110, 2'b00, 16'h0000);
    @(negedge clk);
    check_value("t4_miss_resp", mem_resp, 1'b0);
    next_cycle();
    @(negedge clk);
    check_value("t4_no_write", pmem_write, 1'b0);
    check_value("t4_read", pmem_read, 1'b1);
    check_value("t4_addr", pmem_address, 16'h0110);
    ack_pmem(1, line_c);
    @(negedge clk);
    check_value("t4_rdata", mem_rdata, 16'h1100);

    // Masked write (byte enable 00): data unchanged but the line becomes dirty.
    next_cycle();
    drive_req(1'b0, 1'b1, 16'h0110, 2'b00, 16'hFFFF);
    @(negedge clk);
    check_value("t4m_wr_resp", mem_resp, 1'b1);
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0110, 2'b00, 16'h0000);
    @(negedge clk);
    check_value("t4m_rdata", mem_rdata, 16'h1100);
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);
    next_cycle();
    @(negedge clk);
    check_value("t4m_wb_write", pmem_write, 1'b1);
    check_value("t4m_wb_addr", pmem_address, 16'h0110);
    check_value("t4m_wb_word0", pmem_wdata[15:0], 16'h1100);
    ack_pmem(1, 128'h0);
    @(negedge clk);
    check_value("t4m_alloc_addr", pmem_address, 16'h0010);
    ack_pmem(1, line_a);
    @(negedge clk);
    check_value("t4m_rdata2", mem_rdata, 16'h1234);

    // Test 5: reset asserted while a fill is outstanding.
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000);
    next_cycle();
    @(negedge clk);
    check_value("t5_read_before", pmem_read, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check_value("t5_read_dropped", pmem_read, 1'b0);
    check_value("t5_resp_low", mem_resp, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_value("t5_remiss_resp", mem_resp, 1'b0);
    next_cycle();
    @(negedge clk);
    check_value("t5_reread", pmem_read, 1'b1);
    check_value("t5_reread_addr", pmem_address, 16'h0020);
    ack_pmem(1, line_d);
    @(negedge clk);
    check_value("t5_rdata", mem_rdata, 16'h2020);
    next_cycle();
    drive_req(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);

`ifdef L1_DCACHE_PERF_CNT_EN
    // Test 6: performance counters.
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    check_value("t6_hit_rst", hit_count, 16'h0000);
    check_value("t6_miss_rst", miss_count, 16'h0000);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);
    next_cycle();
    ack_pmem(1, line_a);
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000);
    next_cycle();
    drive_req(1'b1, 1'b0, 16'h0090, 2'b00, 16'h0000);
    next_cycle();
    ack_pmem(1, line_b);
    next_cycle();
    drive_req(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    @(negedge clk);
    check_value("t6_hit_count", hit_count, 16'h0002);
    check_value("t6_miss_count", miss_count, 16'h0002);
`endif

    repeat (2) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
